// File: rtl/itr_ctrl.sv
// Interrupt controller feeding the single itr input of a core_fx instance.
// Latches request-line rising edges, arbitrates round-robin and paces itr pulses behind an ISR ack.
module itr_ctrl #(
  parameter int NSRC      = 4,
  parameter int NUBITS    = 32,
  parameter int NUIOIN    = 8,
  parameter int NUIOOU    = 8,
  parameter int ADDR_MASK = 6,
  parameter int ADDR_ACK  = 7,
  parameter int ADDR_STAT = 7,
  parameter int HOLDOFF   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NSRC-1:0]           src,
  input  logic                      out_en,
  input  logic [$clog2(NUIOOU)-1:0] addr_out,
  input  logic [NUBITS-1:0]         data_out,
  input  logic                      req_in,
  input  logic [$clog2(NUIOIN)-1:0] addr_in,
  output logic                      stat_sel,
  output logic [NUBITS-1:0]         stat_data,
  output logic                      itr,
  output logic                      busy
);

  localparam int IDW = $clog2(NSRC);
  localparam int AOW = $clog2(NUIOOU);
  localparam int AIW = $clog2(NUIOIN);
  localparam int CW  = $clog2(HOLDOFF + 1);

  localparam logic [AOW-1:0] MASK_A = AOW'(ADDR_MASK);
  localparam logic [AOW-1:0] ACK_A  = AOW'(ADDR_ACK);
  localparam logic [AIW-1:0] STAT_A = AIW'(ADDR_STAT);

  typedef enum logic [1:0] {IDLE, FIRE, SERVICE, HOLD} state_t;

  state_t           state;
  logic [NSRC-1:0]  src_d;
  logic [NSRC-1:0]  pending;
  logic [NSRC-1:0]  ovf;
  logic [NSRC-1:0]  mask;
  logic [IDW-1:0]   cur_id;
  logic [IDW-1:0]   rr_ptr;
  logic [CW-1:0]    cnt;

  logic [NSRC-1:0]  rise;
  logic [NSRC-1:0]  clr;
  logic [NSRC-1:0]  elig;
  logic [IDW-1:0]   win;
  logic [IDW-1:0]   win_nxt;
  logic             ack_hit;
  logic             mask_wr;
  logic             unused_data;

  // First set bit of req at or above ptr, wrapping around.
  function automatic logic [IDW-1:0] rr_pick(input logic [NSRC-1:0] req,
                                             input logic [IDW-1:0]  ptr);
    logic [IDW-1:0] w;
    logic           found;
    int             idx;
    w     = '0;
    found = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(ptr) + k) % NSRC;
      if (!found && req[idx]) begin
        w     = IDW'(idx);
        found = 1'b1;
      end
    end
    return w;
  endfunction

  assign rise        = src & ~src_d;
  assign elig        = pending & mask;
  assign win         = rr_pick(elig, rr_ptr);
  assign win_nxt     = (win == IDW'(NSRC - 1)) ? '0 : win + 1'b1;
  assign ack_hit     = (state == SERVICE) && out_en && (addr_out == ACK_A);
  assign mask_wr     = out_en && (addr_out == MASK_A);
  assign stat_sel    = req_in && (addr_in == STAT_A);
  assign unused_data = ^data_out[NUBITS-1:NSRC];

  always_comb begin
    clr = '0;
    for (int i = 0; i < NSRC; i++)
      clr[i] = ack_hit && (cur_id == IDW'(i));
  end

  always_comb begin
    stat_data                          = '0;
    stat_data[NSRC-1:0]                = pending;
    stat_data[2*NSRC-1:NSRC]           = ovf;
    stat_data[2*NSRC+IDW-1:2*NSRC]     = cur_id;
    stat_data[NUBITS-1]                = busy;
  end

  // Request capture: a new edge always wins over an ack clear or a status-read clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_d   <= '0;
      pending <= '0;
      ovf     <= '0;
      mask    <= '0;
    end else begin
      src_d   <= src;
      pending <= rise | (pending & ~clr);
      ovf     <= (rise & pending & ~clr) | (ovf & ~{NSRC{stat_sel}});
      if (mask_wr)
        mask <= data_out[NSRC-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      itr    <= 1'b0;
      busy   <= 1'b0;
      cur_id <= '0;
      rr_ptr <= '0;
      cnt    <= '0;
    end else begin
      itr <= 1'b0;
      case (state)
        IDLE: begin
          if (|elig) begin
            cur_id <= win;
            rr_ptr <= win_nxt;
            itr    <= 1'b1;
            busy   <= 1'b1;
            state  <= FIRE;
          end
        end
        FIRE: state <= SERVICE;
        SERVICE: begin
          if (ack_hit) begin
            cnt   <= CW'(HOLDOFF);
            busy  <= 1'b0;
            state <= HOLD;
          end
        end
        HOLD: begin
          if (cnt == CW'(1))
            state <= IDLE;
          else
            cnt <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_itr_ctrl.sv
// Randomized scoreboard bench for itr_ctrl: a timestamp-based reference model predicts itr pulses
// and status words; a negedge monitor pops and compares them.
module tb_itr_ctrl;
  localparam int NSRC      = 4;
  localparam int NUBITS    = 32;
  localparam int NUIOIN    = 8;
  localparam int NUIOOU    = 8;
  localparam int ADDR_MASK = 6;
  localparam int ADDR_ACK  = 7;
  localparam int ADDR_STAT = 7;
  localparam int HOLDOFF   = 2;
  localparam int IDW = $clog2(NSRC);
  localparam int AOW = $clog2(NUIOOU);
  localparam int AIW = $clog2(NUIOIN);

  if (2*NSRC + IDW >= NUBITS - 1) begin : g_param_chk
    initial $fatal(1, "FAIL param_check: status fields do not fit in NUBITS=%0d", NUBITS);
  end

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NSRC-1:0]   src = '0;
  logic              out_en = 1'b0;
  logic [AOW-1:0]    addr_out = '0;
  logic [NUBITS-1:0] data_out = '0;
  logic              req_in = 1'b0;
  logic [AIW-1:0]    addr_in = '0;
  logic              stat_sel;
  logic [NUBITS-1:0] stat_data;
  logic              itr;
  logic              busy;

  always #5 clk = ~clk;

  itr_ctrl #(
    .NSRC(NSRC), .NUBITS(NUBITS), .NUIOIN(NUIOIN), .NUIOOU(NUIOOU),
    .ADDR_MASK(ADDR_MASK), .ADDR_ACK(ADDR_ACK), .ADDR_STAT(ADDR_STAT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk(clk), .rst(rst), .src(src), .out_en(out_en), .addr_out(addr_out),
    .data_out(data_out), .req_in(req_in), .addr_in(addr_in), .stat_sel(stat_sel),
    .stat_data(stat_data), .itr(itr), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: per-source flags plus timestamps of the controller's commitments.
  bit [NSRC-1:0] m_pend, m_ovf, m_mask, m_srcd, m_rise;
  int  m_cur, m_rr, m_gedge, m_ready, ecount;
  bit  m_svc, m_ack, m_rd;
  int  itr_edge_q[$];
  int  itr_id_q[$];
  logic [NUBITS-1:0] stat_q[$];

  function automatic logic [NUBITS-1:0] model_status();
    logic [NUBITS-1:0] s;
    s = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (m_pend[i]) s = s | (NUBITS'(1) << i);
      if (m_ovf[i])  s = s | (NUBITS'(1) << (NSRC + i));
    end
    s = s | (NUBITS'(m_cur) << (2*NSRC));
    if (m_svc) s = s | (NUBITS'(1) << (NUBITS - 1));
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend = '0; m_ovf = '0; m_mask = '0; m_srcd = '0;
      m_cur = 0; m_rr = 0; m_svc = 0; m_ready = 0; m_gedge = 0;
      itr_edge_q.delete();
      itr_id_q.delete();
    end else begin
      ecount++;
      m_rise = src & ~m_srcd;
      m_srcd = src;
      m_ack  = m_svc && out_en && (int'(addr_out) == ADDR_ACK) && (ecount >= m_gedge + 2);
      m_rd   = req_in && (int'(addr_in) == ADDR_STAT);
      // Controller: acknowledge, or grant when idle long enough and something is eligible.
      if (m_ack) begin
        m_svc   = 0;
        m_ready = ecount + HOLDOFF + 1;
      end else if (!m_svc && ecount >= m_ready && (m_pend & m_mask) != 0) begin
        for (int k = 0; k < NSRC; k++) begin
          int j;
          j = (m_rr + k) % NSRC;
          if (!m_svc && m_pend[j] && m_mask[j]) begin
            m_cur   = j;
            m_svc   = 1;
          end
        end
        m_rr    = (m_cur + 1) % NSRC;
        m_gedge = ecount;
        itr_edge_q.push_back(ecount);
        itr_id_q.push_back(m_cur);
      end
      if (m_rd) m_ovf = '0;
      for (int i = 0; i < NSRC; i++) begin
        bit acked;
        acked = m_ack && (i == m_cur);
        if (m_rise[i]) begin
          if (m_pend[i] && !acked) m_ovf[i] = 1;
          m_pend[i] = 1;
        end else if (acked) begin
          m_pend[i] = 0;
        end
      end
      if (out_en && int'(addr_out) == ADDR_MASK) m_mask = data_out[NSRC-1:0];
    end
  end

  // Monitor
  always @(negedge clk) begin
    logic [NUBITS-1:0] exp_s;
    if (itr_edge_q.size() > 0 && itr_edge_q[0] < ecount) begin
      checks++; errors++;
      $display("FAIL itr_missing: itr=0, required a pulse for source %0d after edge %0d", itr_id_q[0], itr_edge_q[0]);
      void'(itr_edge_q.pop_front());
      void'(itr_id_q.pop_front());
    end
    if (itr) begin
      checks++;
      if (itr_edge_q.size() == 0 || itr_edge_q[0] != ecount) begin
        errors++;
        $display("FAIL itr_unexpected: itr=1 after edge %0d, required itr=0", ecount);
      end else begin
        if (int'(stat_data[2*NSRC +: IDW]) != itr_id_q[0]) begin
          errors++;
          $display("FAIL itr_id: granted %0d, required %0d", stat_data[2*NSRC +: IDW], itr_id_q[0]);
        end
        void'(itr_edge_q.pop_front());
        void'(itr_id_q.pop_front());
      end
    end
    if (stat_q.size() > 0) begin
      exp_s = stat_q.pop_front();
      checks++;
      if (!stat_sel || stat_data !== exp_s || busy !== exp_s[NUBITS-1]) begin
        errors++;
        $display("FAIL status: sel=%b data=%h busy=%b, required sel=1 data=%h busy=%b",
                 stat_sel, stat_data, busy, exp_s, exp_s[NUBITS-1]);
      end
    end else if (stat_sel) begin
      checks++; errors++;
      $display("FAIL stat_sel: stat_sel=1 for addr_in=%0d, required 0", addr_in);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    out_en = 1'b0; addr_out = '0; data_out = '0; req_in = 1'b0; addr_in = '0;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic wr(input int a, input logic [NUBITS-1:0] d);
    out_en = 1'b1; addr_out = AOW'(a); data_out = d;
  endtask

  task automatic rd();
    req_in = 1'b1; addr_in = AIW'(ADDR_STAT);
    stat_q.push_back(model_status());
  endtask

  // Waits (bounded) until the model is in its service phase, then acks with src driven to s.
  task automatic ack_when_busy(input logic [NSRC-1:0] s);
    int n;
    n = 0;
    while (!(m_svc && ecount >= m_gedge + 1) && n < 40) begin
      step();
      n++;
    end
    if (n >= 40) begin
      checks++; errors++;
      $display("FAIL ack_wait: no service phase within 40 cycles, required one");
    end else begin
      wr(ADDR_ACK, $urandom);
      src = s;
      step();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, r;
    step(); step();
    rst = 1'b0;
    rd(); step();
    // Single request, ack, holdoff, queued second request
    wr(ADDR_MASK, 'hF); step();
    src[2] = 1'b1; step(); src[2] = 1'b0; run(3);
    rd(); step();
    src[0] = 1'b1; step(); src[0] = 1'b0;
    ack_when_busy(src); rd(); step();
    run(8); ack_when_busy(src); run(4);
    // All sources at once, then a wrapping pair
    src = '1; step(); src = '0;
    repeat (NSRC) begin ack_when_busy(src); rd(); step(); end
    run(4);
    src = 4'b1010; step(); src = '0;
    repeat (2) ack_when_busy(src);
    run(6);
    // Masked pending source released by a mask write
    wr(ADDR_MASK, 'h1); step();
    src[1] = 1'b1; step(); src[1] = 1'b0; run(6);
    rd(); step();
    wr(ADDR_MASK, 'h3); step();
    ack_when_busy(src); run(4);
    // Overflow, status-read clear, ack colliding with a new edge
    src[0] = 1'b1; step(); src[0] = 1'b0; step();
    src[0] = 1'b1; step(); src[0] = 1'b0; run(2);
    rd(); step(); rd(); step();
    ack_when_busy(4'b0001);
    src[0] = 1'b0; rd(); step();
    run(6); ack_when_busy(src); run(4);
    // Asynchronous reset mid-service, line held high through release
    wr(ADDR_MASK, 'hF); step();
    src[2] = 1'b1; step(); src[2] = 1'b0; run(4);
    rst = 1'b1; src[3] = 1'b1;
    #1; rd(); step(); run(1);
    rst = 1'b0; run(4);
    rd(); step();
    wr(ADDR_MASK, 'h8); step();
    ack_when_busy(src); src[3] = 1'b0; run(4);
    // Randomized traffic
    repeat (2500) begin
      for (int i = 0; i < NSRC; i++)
        if ($urandom_range(5) == 0) src[i] = ~src[i];
      if ($urandom_range(39) == 0) wr(ADDR_MASK, $urandom);
      else if (m_svc && $urandom_range(2) == 0) wr(ADDR_ACK, $urandom);
      else if ($urandom_range(29) == 0) wr(ADDR_ACK, $urandom);
      else if ($urandom_range(9) == 0) wr($urandom_range(0, 5), $urandom);
      r = $urandom_range(9);
      if (r < 2) rd();
      else if (r == 2) begin
        a = $urandom_range(0, NUIOIN - 1);
        req_in = 1'b1; addr_in = AIW'(a);
        if (a == ADDR_STAT) stat_q.push_back(model_status());
      end
      step();
    end
    src = '0;
    run(20);
    checks++;
    if (itr_edge_q.size() != 0 || stat_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d itr and %0d status expectations left, required 0",
               itr_edge_q.size(), stat_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
